// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock; done after BIN_W+1 cycles.
// No backpressure: start is honoured only in IDLE, otherwise dropped; the result holds until the next done.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [BIN_W-1:0] bin_q;
  logic [W-1:0]     work_q;
  logic [CW-1:0]    cnt_q;
  logic             ovf_acc_q;
  logic [W-1:0]     bcd_q;
  logic             ovf_q;

  logic [W-1:0]     adj;
  logic [W-1:0]     work_nx;
  logic             ovf_nx;
  logic             last_step;

  assign last_step = (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (last_step) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_SHIFT);
    done = (state_q == S_DONE);
  end

  // Add-3 on every digit >= 5 in parallel, then shift the binary MSB into digit 0.
  always_comb begin
    adj = work_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (work_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
    end
    work_nx = {adj[W-2:0], bin_q[BIN_W-1]};
    ovf_nx  = ovf_acc_q | adj[W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q     <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (start) begin
        bin_q     <= bin;
        work_q    <= '0;
        ovf_acc_q <= 1'b0;
        cnt_q     <= CW'(BIN_W);
      end
    end else if (state_q == S_SHIFT) begin
      bin_q     <= bin_q << 1;
      work_q    <= work_nx;
      ovf_acc_q <= ovf_nx;
      cnt_q     <= cnt_q - CW'(1);
      // Publish on the final step so bcd/overflow are already valid while done is high.
      if (last_step) begin
        bcd_q <= work_nx;
        ovf_q <= ovf_nx;
      end
    end
  end

  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance share clock, reset and stimulus.
`timescale 1ns/1ps
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin;
  logic        busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;

  int vectors = 0;
  int miscompares = 0;
  int starts = 0;
  int done_cnt3 = 0;
  int done_cnt2 = 0;
  logic [11:0] last3;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy3), .done(done3), .bcd(bcd3), .overflow(ovf3)
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done3) done_cnt3++;
    if (done2) done_cnt2++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic digits_ok(input logic [11:0] b);
    return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (b[11:8] <= 4'd9);
  endfunction

  // Caller is just after a negedge with the DUT in IDLE; returns just after the negedge following done.
  task automatic convert(input logic [7:0] v, input logic inject,
                         input logic [11:0] e3, input logic eo3,
                         input logic [7:0] e2, input logic eo2);
    int lat;
    int busyc;
    lat   = 0;
    busyc = 0;
    start = 1'b1;
    bin   = v;
    starts++;
    for (int i = 1; i <= 30 && lat == 0; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 4) chk("bcd_hold", bcd3, last3);
      if (inject && i == 3) begin
        start = 1'b1;
        bin   = 8'd7;
      end
      if (inject && i == 4) start = 1'b0;
      if (busy3) busyc++;
      if (done3) lat = i;
    end
    chk("latency", lat, 9);
    chk("busy_cycles", busyc, 8);
    chk("bcd3", bcd3, e3);
    chk("ovf3", ovf3, eo3);
    chk("bcd2", bcd2, e2);
    chk("ovf2", ovf2, eo2);
    chk("digits_valid", digits_ok(bcd3), 1'b1);
    last3 = bcd3;
    @(negedge clk);
    chk("done_single", done3, 1'b0);
    chk("idle_busy", busy3, 1'b0);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    bin   = 8'd0;
    last3 = 12'h000;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy3, 1'b0);
    chk("rst_done", done3, 1'b0);
    chk("rst_bcd", bcd3, 12'h000);
    chk("rst_ovf", ovf3, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back directed vectors, each started on the first IDLE cycle.
    convert(8'd0,   1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
    convert(8'd255, 1'b0, 12'h255, 1'b0, 8'h55, 1'b1);
    convert(8'd99,  1'b0, 12'h099, 1'b0, 8'h99, 1'b0);
    convert(8'd100, 1'b0, 12'h100, 1'b0, 8'h00, 1'b1);
    // Second start and changed bin mid-conversion must be ignored.
    convert(8'd42,  1'b1, 12'h042, 1'b0, 8'h42, 1'b0);

    // Asynchronous reset between edges in the middle of a conversion.
    start = 1'b1;
    bin   = 8'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy3, 1'b0);
    chk("arst_done", done3, 1'b0);
    chk("arst_bcd", bcd3, 12'h000);
    chk("arst_ovf", ovf3, 1'b0);
    chk("arst_bcd2", bcd2, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    last3 = 12'h000;
    d0 = done_cnt3;
    repeat (20) @(negedge clk);
    chk("no_done_after_rst", done_cnt3 - d0, 0);
    chk("idle_after_rst", busy3, 1'b0);

    // Two-digit overflow corner cases.
    convert(8'd200, 1'b0, 12'h200, 1'b0, 8'h00, 1'b1);
    convert(8'd150, 1'b0, 12'h150, 1'b0, 8'h50, 1'b1);
    convert(8'd99,  1'b0, 12'h099, 1'b0, 8'h99, 1'b0);

    for (int v = 0; v < 256; v++) begin
      convert(8'(v), 1'b0,
              {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)}, 1'b0,
              {4'((v / 10) % 10), 4'(v % 10)}, (v >= 100));
    end

    chk("done_count3", done_cnt3, starts);
    chk("done_count2", done_cnt2, starts);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm. It runs one bit per clock.
It sits directly upstream of the BCD digit adder and supplies packed 4-bit BCD digits for its A/B operands.
A start/busy/done handshake frames each conversion. The result is held stable between conversions.

Parameters:
BIN_W, 8, width of the binary input (>= 1)
DIGITS, 3, number of BCD digits produced (>= 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request conversion; sampled only in IDLE
bin  input  BIN_W  binary operand; captured on the accepted start cycle
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bcd/overflow are updated
bcd  output  4*DIGITS  packed result; digit k in bits [4k+3:4k], digit 0 = units
overflow  output  1  high if the value exceeds 10^DIGITS-1; qualified with bcd

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, bcd=0, overflow=0; internal shift register, counter and overflow accumulator cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1 at edge n: capture bin into the binary shift register; clear the BCD working register and the overflow accumulator; load bit counter = BIN_W; go to SHIFT.
  - busy=1 from edge n onward.
- SHIFT, one step per cycle:
  - For each digit of the working register that is >= 5, add 3 (all digits in parallel, 4-bit arithmetic, no inter-digit carry).
  - Shift the concatenation {working register, binary register} left by 1. The binary MSB enters digit 0 bit 0.
  - The bit shifted out of the top digit's MSB is ORed into the overflow accumulator.
  - Decrement the counter. When it reaches 0 after this step, go to DONE.
- DONE (one cycle):
  - bcd <= working register; overflow <= accumulator.
  - done=1 for exactly this cycle; busy=0 this cycle.
  - Go to IDLE.
- Latency: start accepted at edge n → done high and new bcd visible during cycle n+BIN_W+1. busy is high for exactly BIN_W cycles.
- Throughput: the next start is accepted only in IDLE, at the edge after done at the earliest. Minimum spacing between accepted starts is BIN_W+2 cycles.
- start while busy=1 or in DONE: ignored (no queuing); bin changes during a conversion are ignored.
- bcd/overflow hold the previous result until the next DONE. They are never partially updated.
- Overflow case: bcd = value mod 10^DIGITS (the lower digits stay exact), and overflow=1.
- Every output digit is always 0–9; a digit value 10–15 on bcd is an error.
- Reset asserted mid-SHIFT: conversion aborted, all outputs return to reset values immediately, no done pulse. After release, IDLE waits for a new start.
- Width rules:
  - Counter width is clog2(BIN_W+1).
  - Working register is 4*DIGITS bits.
  - No parameter combination may produce truncation other than the defined overflow path.

Test Plan:
- Reset then start with bin=0 → done pulse 9 cycles after the accepted start edge; bcd=12'h000, overflow=0; busy high exactly 8 cycles.
- bin=8'd255 → bcd=12'h255, overflow=0. Then bin=8'd99 → 12'h099. Then bin=8'd100 → 12'h100. Starts are issued back-to-back, each on the first IDLE cycle; each done is a single cycle.
- Start pulsed again at cycle 3 of a busy conversion, with bin changed to 8'd7 mid-run → ignored; original result delivered; no extra done.
- rst_n dropped asynchronously mid-SHIFT (between edges) → busy, done, bcd and overflow go to 0 immediately. After release with start=0, no done pulse for 20 cycles.
- DIGITS=2, BIN_W=8, bin=8'd200 → bcd=8'h00, overflow=1. bin=8'd150 → bcd=8'h50, overflow=1. bin=8'd99 → bcd=8'h99, overflow=0.
- Exhaustive sweep: all 256 inputs (default parameters) → bcd equals the decimal encoding of bin; no digit > 9; done count equals start count.
